pipe_stage_chain: RTL
=====================

Name: pipe_stage_chain

Overview:
- Parametrised elastic pipeline-register chain that generalises the fixed IF_ID/ID_EX/EX_MEM/MEM_WB registers into DEPTH identical stages.
- Each stage carries a data word, a control word and a valid bit.
- Adds per-stage hold (stall), flush (squash of a stage and everything younger), automatic bubble insertion with control zeroing, valid/ready handshakes at both ends, and a stall-cycle counter.
- Replaces the hard-wired PCWrite/if_id_write=1 path. Hazard units drive hold/flush.

Parameters:
- DEPTH, 4, number of stages (>=2). Stage 0 is youngest (input side); stage DEPTH-1 is oldest (output side).
- DATA_W, 128, data payload width per stage.
- CTRL_W, 8, control payload width per stage. Zeroed whenever a stage is invalid.
- CNT_W, 32, stall counter width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; acts on the clock edge when low.
- in_valid  input  1  upstream offers an entry.
- in_ready  output  1  stage 0 accepts this cycle.
- in_data  input  DATA_W  entry data.
- in_ctrl  input  CTRL_W  entry control.
- hold  input  DEPTH  hold[k]=1 freezes stage k this cycle.
- flush  input  DEPTH  flush[k]=1 squashes stages 0..k and the input.
- out_valid  output  1  stage DEPTH-1 valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  stage DEPTH-1 data.
- out_ctrl  output  CTRL_W  stage DEPTH-1 control, masked by valid.
- stage_valid  output  DEPTH  valid bit of every stage.
- stall_cnt  output  CNT_W  cycles with in_valid=1 and in_ready=0; saturating.

Behaviour:
- Reset (reset=0 at an edge):
  - All valid bits, data, ctrl and stall_cnt go to 0.
  - Overrides hold, flush and handshakes; an in-flight transfer is discarded.
  - While in reset: in_ready=0, out_valid=0, out_ctrl=0.
- Ready chain (combinational, oldest to youngest):
  - rdy[DEPTH] = out_ready.
  - rdy[k] = !hold[k] & (!valid[k] | rdy[k+1]).
  - in_ready = rdy[0].
- Advance: stage k loads from stage k-1 (or the input for k=0) when rdy[k]=1.
  - The loaded valid is the source valid (in_valid for k=0).
  - Otherwise stage k keeps its contents.
- Bubble: if rdy[k]=1 and the source is invalid, stage k becomes invalid and its ctrl is written 0. Data is don't-care but is written 0.
- Output transfer: occurs when out_valid & out_ready.
- Hold on an empty stage blocks it from accepting. Hold never drops data.
- Flush mask:
  - fm[j] = OR(flush[j..DEPTH-1]).
  - When fm[j]=1, stage j's next valid is 0, whatever it loads or holds. Flush overrides hold.
  - If fm[0]=1, an input handshake in that cycle completes (in_ready as computed) but the entry is dropped.
  - Stage k+1 with fm[k+1]=0 loading from a flushed stage k receives a bubble: valid=0, ctrl=0.
- Flush and out_ready: flush never affects the out_ready handshake on the current output entry. The entry is already committed.
- Latency: DEPTH cycles from input handshake to out_valid with no holds.
- Throughput: 1 entry/cycle when out_ready=1 and hold=0.
- Outputs: out_ctrl = valid[DEPTH-1] ? ctrl[DEPTH-1] : 0. stage_valid is registered state.
- stall_cnt:
  - Increments when in_valid & !in_ready & reset=1.
  - Saturates at all-ones. No wrap.
- Simultaneous events, priority: reset > flush > hold > advance.

Decomposition:
- Package pipe_pkg:
  - PIPE_DEPTH_DEF, PIPE_DATA_W_DEF, PIPE_CTRL_W_DEF.
  - typedef pipe_slot_t {valid, ctrl, data}, parametrised via the package defaults.
- Sub-module pipe_stage_slot (one stage):
  - Inputs: clock, reset, load, squash, src slot.
  - Output: current slot.
  - Ctrl zeroing on invalid is handled inside the slot.
- The chain generates DEPTH slots, plus the ready/flush-mask logic and stall_cnt.

Test Plan:
- Streaming: DEPTH=4, out_ready=1, hold=0. Feed data 1..8 back-to-back. out_valid first rises 4 cycles after the first handshake, then outputs 1..8 on consecutive cycles. stall_cnt=0.
- Backpressure: out_ready=0 with 6 entries offered. Stages fill with 1..4 and in_ready=0 from the 5th offer. stall_cnt counts 1 per blocked cycle. Release out_ready: order 1..6 is preserved with no loss.
- Hold mid-pipe: hold[1]=1 for 3 cycles while streaming.
  - Stage 1 freezes; stage 0 fills then blocks.
  - Stages 2 and 3 drain, producing bubbles with stage_valid[2]=0 and out_ctrl=0.
  - Resume: no duplicates.
- Flush: stages hold entries A(s0) B(s1) C(s2) D(s3); assert flush[1] with in_valid=1, entry E.
  - Next cycle: s0, s1 and s2 are invalid and E is dropped.
  - D transfers out if out_ready=1. C advances into s3 intact.
- Flush vs hold: hold[2]=1 and flush[2]=1 in the same cycle. Stage 2 becomes invalid (flush wins).
- Reset: pull reset low during a full-pipe backpressure stall. After one edge, stage_valid=0, out_ctrl=0 and stall_cnt=0. Streaming resumes correctly after reset returns high.
- Saturation: CNT_W=4 with 20 stalled cycles. stall_cnt holds at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared defaults and slot bundle for the elastic pipeline-register chain.
// Imported by pipe_stage_slot and pipe_stage_chain.
package pipe_pkg;

    localparam int PIPE_DEPTH_DEF  = 4;
    localparam int PIPE_DATA_W_DEF = 128;
    localparam int PIPE_CTRL_W_DEF = 8;
    localparam int PIPE_CNT_W_DEF  = 32;

    // One pipeline slot at the default widths. The chain builds its own
    // local equivalent when it is instantiated with other widths.
    typedef struct packed {
        logic                       valid;
        logic [PIPE_CTRL_W_DEF-1:0] ctrl;
        logic [PIPE_DATA_W_DEF-1:0] data;
    } pipe_slot_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline register slot: loads its source when told to, can be squashed,
// and never carries ctrl/data while invalid.
// Ports:
//   clock    - rising-edge clock
//   reset    - synchronous active-low reset
//   load_i   - take src_i this cycle
//   squash_i - force the next valid to 0 (beats load and keep)
//   src_i    - slot offered by the younger neighbour / input
//   slot_o   - registered slot contents
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter type slot_t = pipe_slot_t
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  load_i,
    input  logic  squash_i,
    input  slot_t src_i,
    output slot_t slot_o
);

    slot_t slot_q;
    slot_t slot_d;

    always_comb begin
        slot_d = slot_q;
        if (load_i) begin
            slot_d = src_i;
        end
        if (squash_i) begin
            slot_d.valid = 1'b0;
        end
        // A bubble never leaks stale control into later stages.
        if (!slot_d.valid) begin
            slot_d.ctrl = '0;
            slot_d.data = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic chain of DEPTH pipeline slots with hold, flush, bubbles,
// valid/ready at both ends and a saturating input-stall counter.
// Ports:
//   clock, reset            - clock, synchronous active-low reset
//   in_valid/in_ready       - input handshake, in_data/in_ctrl payload
//   hold[k]                 - freeze stage k this cycle
//   flush[k]                - squash stages 0..k and the input entry
//   out_valid/out_ready     - output handshake, out_data/out_ctrl payload
//   stage_valid             - registered valid bit of every stage
//   stall_cnt               - cycles with in_valid & !in_ready (saturating)
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int DEPTH  = PIPE_DEPTH_DEF,
    parameter int DATA_W = PIPE_DATA_W_DEF,
    parameter int CTRL_W = PIPE_CTRL_W_DEF,
    parameter int CNT_W  = PIPE_CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DEPTH-1:0]  hold,
    input  logic [DEPTH-1:0]  flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DEPTH-1:0]  stage_valid,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } slot_t;

    slot_t            cur [DEPTH];
    slot_t            src [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] fm;

    for (genvar k = 0; k < DEPTH; k++) begin : g_vld
        assign vld[k] = cur[k].valid;
    end

    // Ready ripples from the output back to the input.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = !hold[k] & (!vld[k] | rdy[k+1]);
        end
    end

    // A flush of stage k also kills every younger stage.
    always_comb begin
        fm            = '0;
        fm[DEPTH-1]   = flush[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            fm[k] = flush[k] | fm[k+1];
        end
    end

    // A held or flushed stage offers a bubble to its older neighbour, so
    // its entry is neither duplicated nor resurrected downstream.
    always_comb begin
        src[0].valid = in_valid;
        src[0].ctrl  = in_ctrl;
        src[0].data  = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            src[k]       = cur[k-1];
            src[k].valid = cur[k-1].valid & !fm[k-1] & !hold[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        pipe_stage_slot #(
            .slot_t (slot_t)
        ) u_slot (
            .clock    (clock),
            .reset    (reset),
            .load_i   (rdy[k]),
            .squash_i (fm[k]),
            .src_i    (src[k]),
            .slot_o   (cur[k])
        );
    end

    assign in_ready    = rdy[0] & reset;
    assign out_valid   = vld[DEPTH-1] & reset;
    assign out_data    = cur[DEPTH-1].data;
    assign out_ctrl    = out_valid ? cur[DEPTH-1].ctrl : '0;
    assign stage_valid = vld;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && !in_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule
